// File: rtl/nx_loader_pkg.sv
// Shared definitions for the boot loader.
//   - header target codes (bits [31:30] of a header word)
//   - loader FSM state encoding
//   - header field bit positions
package nx_loader_pkg;

  typedef enum logic [1:0] {
    TGT_INST = 2'b00,
    TGT_DATA = 2'b01,
    TGT_REG  = 2'b10,
    TGT_END  = 2'b11
  } tgt_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_e;

  // Header layout: [31:30] target, [29:16] word count, [15:0] ignored.
  localparam int HDR_TGT_LSB = 30;
  localparam int HDR_CNT_LSB = 16;

endpackage

// File: rtl/nx_boot_loader.sv
// Boot-time loader: consumes a 32-bit command stream (header / address /
// data words) and preloads instruction RAM, data RAM and register file, then
// releases the core reset once an END header is accepted.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 begin a load session (pulse, honoured in IDLE/DONE/ERR)
//   cmd_valid/ready/data  command word handshake
//   inst_ram_*            instruction RAM write port (registered)
//   data_ram_*_initial    data RAM write port (registered)
//   regfile_*_initial     register file write port (registered, x0 suppressed)
//   core_rst_n            core reset, high only in DONE
//   busy / done / err     session status derived from the state register
module nx_boot_loader
  import nx_loader_pkg::*;
#(
  parameter int CNT_W    = 14,
  parameter int RAM_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  output logic        inst_ram_wen,
  output logic [31:0] inst_ram_waddr,
  output logic [31:0] inst_ram_wdata,
  output logic        data_ram_wen_initial,
  output logic [31:0] data_ram_waddr_initial,
  output logic [31:0] data_ram_wdata_initial,
  output logic        regfile_wen_initial,
  output logic [4:0]  regfile_waddr_initial,
  output logic [31:0] regfile_wdata_initial,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_e             state_q, state_d;
  tgt_e               tgt_q, tgt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        ptr_q, ptr_d;

  logic               iwen_q, iwen_d;
  logic [31:0]        iaddr_q, iaddr_d, idata_q, idata_d;
  logic               dwen_q, dwen_d;
  logic [31:0]        daddr_q, daddr_d, ddata_q, ddata_d;
  logic               rwen_q, rwen_d;
  logic [4:0]         raddr_q, raddr_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               accept;
  tgt_e               hdr_tgt;
  logic [CNT_W-1:0]   hdr_cnt;

  assign cmd_ready = (state_q == HDR) || (state_q == ADDR) || (state_q == DATA);
  assign accept    = cmd_valid && cmd_ready;
  assign hdr_tgt   = tgt_e'(cmd_data[HDR_TGT_LSB +: 2]);
  assign hdr_cnt   = cmd_data[HDR_CNT_LSB +: CNT_W];

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    // strobes are single-cycle; addr/data hold unless a write is issued
    iwen_d  = 1'b0; iaddr_d = iaddr_q; idata_d = idata_q;
    dwen_d  = 1'b0; daddr_d = daddr_q; ddata_d = ddata_q;
    rwen_d  = 1'b0; raddr_d = raddr_q; rdata_d = rdata_q;

    unique case (state_q)
      IDLE: if (start) state_d = HDR;
      HDR: if (accept) begin
        if (hdr_tgt == TGT_END) state_d = DONE;
        else if (hdr_cnt != '0) begin
          tgt_d   = hdr_tgt;
          cnt_d   = hdr_cnt;
          state_d = ADDR;
        end
        // zero-count block: stay in HDR, next word is another header
      end
      ADDR: if (accept) begin
        if (tgt_q == TGT_REG) begin
          if (cmd_data[31:5] != '0) state_d = ERR;
          else begin
            ptr_d   = {27'd0, cmd_data[4:0]};
            state_d = DATA;
          end
        end else begin
          ptr_d   = cmd_data;
          state_d = DATA;
        end
      end
      DATA: if (accept) begin
        // register pointer walked past x31: reject the word, no write
        if (tgt_q == TGT_REG && ptr_q[31:5] != '0) state_d = ERR;
        else begin
          unique case (tgt_q)
            TGT_INST: begin iwen_d = 1'b1; iaddr_d = ptr_q; idata_d = cmd_data; end
            TGT_DATA: begin dwen_d = 1'b1; daddr_d = ptr_q; ddata_d = cmd_data; end
            default: begin
              // x0 writes consume the word but never strobe
              if (ptr_q[4:0] != 5'd0) begin
                rwen_d  = 1'b1;
                raddr_d = ptr_q[4:0];
                rdata_d = cmd_data;
              end
            end
          endcase
          ptr_d = (tgt_q == TGT_REG) ? ptr_q + 32'd1 : ptr_q + 32'(RAM_STEP);
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = HDR;
        end
      end
      DONE, ERR: if (start) state_d = HDR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= TGT_INST;
      cnt_q   <= '0;
      ptr_q   <= '0;
      iwen_q  <= 1'b0; iaddr_q <= '0; idata_q <= '0;
      dwen_q  <= 1'b0; daddr_q <= '0; ddata_q <= '0;
      rwen_q  <= 1'b0; raddr_q <= '0; rdata_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      iwen_q  <= iwen_d; iaddr_q <= iaddr_d; idata_q <= idata_d;
      dwen_q  <= dwen_d; daddr_q <= daddr_d; ddata_q <= ddata_d;
      rwen_q  <= rwen_d; raddr_q <= raddr_d; rdata_q <= rdata_d;
    end
  end

  assign inst_ram_wen           = iwen_q;
  assign inst_ram_waddr         = iaddr_q;
  assign inst_ram_wdata         = idata_q;
  assign data_ram_wen_initial   = dwen_q;
  assign data_ram_waddr_initial = daddr_q;
  assign data_ram_wdata_initial = ddata_q;
  assign regfile_wen_initial    = rwen_q;
  assign regfile_waddr_initial  = raddr_q;
  assign regfile_wdata_initial  = rdata_q;

  assign busy       = cmd_ready;
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);
  assign core_rst_n = (state_q == DONE);

endmodule

// File: tb/tb_nx_boot_loader.sv
// Randomized bench for nx_boot_loader. Each session is a list of command
// words; a reference model walks the list by the header/address/data rules
// and predicts the write list plus the final outcome (done or err).
module tb_nx_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, cmd_valid, cmd_ready;
  logic [31:0] cmd_data;
  logic        inst_ram_wen, data_ram_wen_initial, regfile_wen_initial;
  logic [31:0] inst_ram_waddr, inst_ram_wdata;
  logic [31:0] data_ram_waddr_initial, data_ram_wdata_initial, regfile_wdata_initial;
  logic [4:0]  regfile_waddr_initial;
  logic        core_rst_n, busy, done, err;

  always #5 clk = ~clk;

  nx_boot_loader #(.CNT_W(14), .RAM_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .inst_ram_wen(inst_ram_wen), .inst_ram_waddr(inst_ram_waddr), .inst_ram_wdata(inst_ram_wdata),
    .data_ram_wen_initial(data_ram_wen_initial), .data_ram_waddr_initial(data_ram_waddr_initial),
    .data_ram_wdata_initial(data_ram_wdata_initial),
    .regfile_wen_initial(regfile_wen_initial), .regfile_waddr_initial(regfile_waddr_initial),
    .regfile_wdata_initial(regfile_wdata_initial),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  localparam int RES_NONE = 0, RES_DONE = 1, RES_ERR = 2;

  logic [31:0] sess_q[$];
  logic [65:0] exp_q[$];
  logic [65:0] act_q[$];
  int          n_used, exp_res;

  function automatic logic [65:0] mk(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    return {t, a, d};
  endfunction

  // write monitor: every strobe becomes {target, addr, data}
  always @(negedge clk) begin
    int nw;
    nw = int'(inst_ram_wen) + int'(data_ram_wen_initial) + int'(regfile_wen_initial);
    if (nw > 0) chk("onehot_wen", nw, 1);
    if (inst_ram_wen)         act_q.push_back(mk(2'd0, inst_ram_waddr, inst_ram_wdata));
    if (data_ram_wen_initial) act_q.push_back(mk(2'd1, data_ram_waddr_initial, data_ram_wdata_initial));
    if (regfile_wen_initial)  act_q.push_back(mk(2'd2, {27'd0, regfile_waddr_initial}, regfile_wdata_initial));
  end

  // Reference model: interpret the word list block by block.
  task automatic model();
    int i, cnt;
    bit stop;
    logic [31:0] h, a, d;
    logic [1:0]  t;
    exp_q.delete();
    exp_res = RES_NONE; i = 0; stop = 0;
    while (!stop && i < sess_q.size()) begin
      h = sess_q[i]; i++;
      t = h[31:30]; cnt = int'(h[29:16]);
      if (t == 2'd3) begin exp_res = RES_DONE; stop = 1; end
      else if (cnt != 0) begin
        a = sess_q[i]; i++;
        if (t == 2'd2 && a > 32'd31) begin exp_res = RES_ERR; stop = 1; end
        for (int k = 0; k < cnt && !stop; k++) begin
          d = sess_q[i]; i++;
          if (t == 2'd2) begin
            if (a + 32'(k) > 32'd31) begin exp_res = RES_ERR; stop = 1; end
            else if (a + 32'(k) != 32'd0) exp_q.push_back(mk(t, a + 32'(k), d));
          end else exp_q.push_back(mk(t, a + 32'(4 * k), d));
        end
      end
    end
    n_used = i;
  endtask

  task automatic gen();
    logic [1:0]  t;
    logic [13:0] cnt;
    logic [31:0] a;
    sess_q.delete();
    repeat ($urandom_range(1, 4)) begin
      t   = 2'($urandom_range(0, 2));
      cnt = ($urandom_range(0, 4) == 0) ? 14'd0 : 14'($urandom_range(1, 5));
      sess_q.push_back({t, cnt, 16'($urandom)});
      if (cnt != 0) begin
        if (t == 2'd2) a = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 31));
        else a = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF8 : (32'($urandom) & 32'hFFFF_FFFC);
        sess_q.push_back(a);
        repeat (cnt) sess_q.push_back(32'($urandom));
      end
    end
    sess_q.push_back({2'b11, 30'($urandom)});
  endtask

  // drive one word with a random 0-2 cycle gap; returns just after the handshake edge
  task automatic send(input logic [31:0] w);
    int t;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk); cmd_valid = 1'b0; cmd_data = 32'($urandom);
    end
    @(negedge clk); cmd_valid = 1'b1; cmd_data = w;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("handshake_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_state", {busy, cmd_ready, done, err, core_rst_n}, 5'b11000);
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_nwr"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) chk({tag, "_wr"}, act_q[i], exp_q[i]);
    act_q.delete();
  endtask

  task automatic run_session(input string tag);
    model();
    act_q.delete();
    pulse_start();
    for (int i = 0; i < n_used; i++) send(sess_q[i]);
    @(negedge clk); cmd_valid = 1'b0;
    chk({tag, "_end"}, {done, err, core_rst_n, cmd_ready, busy},
        {exp_res == RES_DONE, exp_res == RES_ERR, exp_res == RES_DONE, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    compare_writes(tag);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {cmd_ready, busy, done, err, core_rst_n,
                    inst_ram_wen, data_ram_wen_initial, regfile_wen_initial}, 8'd0);
    chk("rst_bus", |{inst_ram_waddr, inst_ram_wdata, data_ram_waddr_initial, data_ram_wdata_initial,
                     regfile_waddr_initial, regfile_wdata_initial}, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic INST load
    sess_q = '{32'h0003_0000, 32'h0, 32'h11, 32'h22, 32'h33, 32'hC000_0000};
    run_session("basic");
    // mixed DATA + REG with x0 suppressed
    sess_q = '{32'h4002_0000, 32'h100, 32'hA1, 32'hA2,
               32'h8003_0000, 32'h0, 32'hB0, 32'hB1, 32'hB2, 32'hC000_0000};
    run_session("mixed");
    // regfile overflow at x31
    sess_q = '{32'h8002_0000, 32'd31, 32'hC1, 32'hC2, 32'hC000_0000};
    run_session("regovf");
    // zero-count header followed directly by END
    sess_q = '{32'h0000_0000, 32'hC000_0000};
    run_session("zero");
    // RAM pointer wraps
    sess_q = '{32'h0002_0000, 32'hFFFF_FFFC, 32'hD1, 32'hD2, 32'hC000_0000};
    run_session("wrap");

    // reset mid-session: two writes land, then rst_n kills the session
    act_q.delete();
    pulse_start();
    send(32'h0005_0000); send(32'h200); send(32'hE0); send(32'hE1);
    @(negedge clk); rst_n = 1'b0; cmd_valid = 1'b1; cmd_data = 32'hE2;
    @(negedge clk);
    chk("midrst_ctl", {cmd_ready, busy, done, err, core_rst_n,
                       inst_ram_wen, data_ram_wen_initial, regfile_wen_initial}, 8'd0);
    chk("midrst_bus", |{inst_ram_waddr, inst_ram_wdata}, 1'b0);
    rst_n = 1'b1; cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_idle", {busy, cmd_ready}, 2'b00);
    exp_q = '{mk(2'd0, 32'h200, 32'hE0), mk(2'd0, 32'h204, 32'hE1)};
    compare_writes("midrst");
    sess_q = '{32'h0003_0000, 32'h40, 32'h1, 32'h2, 32'h3, 32'hC000_0000};
    run_session("postrst");

    // randomized sessions
    for (int s = 0; s < 40; s++) begin
      gen();
      run_session("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
